fifo_status_bank: RTL
=====================

# fifo_status_bank

Occupancy and status tracker for the five FIFOs (Main FIFO, VC0, VC1, D0, D1) supervised by `maquina`. It counts pushes and pops per FIFO and latches the thresholds the machine publishes while in its init state. It produces the `Fifo_empties`/`Fifo_errors` vectors the machine consumes, plus per-FIFO almost-full/almost-empty flags for the datapath. It sits between the FIFO datapath and `maquina`, closing the loop on the machine's status inputs.

## Interface
- `BITBUS`, 3: threshold width.
- `DEPTH`, 8: capacity of every FIFO, in words.
- `CNT_W`, 4: occupancy counter width; must satisfy 2^CNT_W > DEPTH.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `init_out`  in  1  threshold load enable, driven by `maquina` `init_out`.
- `umbralMF_out`  in  BITBUS  Main FIFO threshold (FIFO 0).
- `umbralVC_out`  in  BITBUS  VC threshold (FIFOs 1–2).
- `umbralD_out`  in  BITBUS  destination threshold (FIFOs 3–4).
- `push`  in  5  per-FIFO write strobe; bit i is FIFO i.
- `pop`  in  5  per-FIFO read strobe.
- `Fifo_empties`  out  5  bit i high when FIFO i count == 0.
- `Fifo_errors`  out  5  bit i high on overflow or underflow of FIFO i.
- `almost_full`  out  5  bit i high when count ≥ DEPTH − thr(i).
- `almost_empty`  out  5  bit i high when count ≤ thr(i).

## Operation
- Threshold registers `thrMF`, `thrVC`, `thrD`:
  - Reset to 0.
  - Loaded from the `*_out` inputs on every edge where `init_out` = 1; held otherwise.
  - A value above DEPTH is clamped to DEPTH at load.
- thr(i) mapping: FIFO 0 → `thrMF`; FIFOs 1–2 → `thrVC`; FIFOs 3–4 → `thrD`.
- Per-FIFO counter `cnt[i]`, range 0..DEPTH, reset to 0. Per edge:
  - push only, cnt < DEPTH: cnt+1.
  - push only, cnt == DEPTH: overflow; cnt unchanged; error.
  - pop only, cnt > 0: cnt−1.
  - pop only, cnt == 0: underflow; cnt unchanged; error.
  - push and pop, 0 < cnt < DEPTH: cnt unchanged; no error.
  - push and pop, cnt == 0: push accepted, pop underflows; cnt = 1; error.
  - push and pop, cnt == DEPTH: pop accepted, push overflows; cnt = DEPTH−1; error.
- Counters never wrap. Comparisons are unsigned at CNT_W bits; `DEPTH − thr` never goes negative because of the clamp.
- All four status vectors are registered. Each is computed from the next-state counter and the currently latched thresholds.
- Reset values: `Fifo_empties` = 5'b11111, `almost_empty` = 5'b11111, `almost_full` = 5'b00000, `Fifo_errors` = 5'b00000.
- Reset mid-operation: counters, thresholds and all outputs return to their reset values on that edge, regardless of `push`/`pop`/`init_out`.

## Timing
- `push`/`pop` sampled at edge k: counter and all status outputs reflect the result after edge k, i.e. visible in cycle k+1. One-cycle latency; no combinational path from input to output.
- Thresholds loaded at edge k: flags computed at edge k use the old thresholds. Flags from edge k+1 onward use the new ones.
- `init_out` held high across many cycles reloads every edge, so the final value wins.
- Channels are fully independent; simultaneous events on different FIFOs are all honoured in the same cycle.

## Configuration
- `FIFO_ERR_STICKY_EN` defined:
  - `Fifo_errors[i]` sets on the first overflow/underflow of FIFO i.
  - It stays high until `reset`, which lets `maquina` hold in its error state.
- Not defined:
  - `Fifo_errors[i]` is high only in the cycle after an erroneous edge.
  - It clears on the next edge with no new error on FIFO i.

## Test plan
- Reset, then idle 3 cycles -> `Fifo_empties` = 11111, `almost_empty` = 11111, `almost_full` = 00000, `Fifo_errors` = 00000.
- `init_out`=1 with `umbralMF_out`=2 for one cycle, then 6 pushes on FIFO 0 -> `Fifo_empties[0]` falls after push 1; `almost_empty[0]` falls after push 3 (cnt 3 > 2); `almost_full[0]` rises after push 6 (6 ≥ 8−2).
- 8 pushes on FIFO 2, then a 9th push -> cnt stays 8 and `Fifo_errors[2]` = 1. Sticky build: it stays 1 for 10 idle cycles. Non-sticky build: it is 0 one cycle later.
- Pop on empty FIFO 4 together with push on FIFO 3 -> `Fifo_errors` = 10000; `Fifo_empties` = 10111.
- FIFO 1 at cnt 0, `push`+`pop` together -> cnt 1, `Fifo_empties[1]` = 0, `Fifo_errors[1]` = 1. Fill FIFO 1 to 8, then `push`+`pop` -> cnt 7, error set.
- FIFO 0 at cnt 5, assert `reset` together with a push -> next cycle cnt 0, all outputs at reset values, thresholds back to 0.

Source files
------------

// File: rtl/fifo_status_bank.sv
// Occupancy and status tracker for the five FIFOs supervised by maquina
// (Main FIFO, VC0, VC1, D0, D1). Counts pushes/pops per FIFO, latches the
// thresholds published during init, and produces registered empty, error,
// almost-full and almost-empty vectors.
//
// Optional feature: define FIFO_ERR_STICKY_EN to make Fifo_errors[i] stick
// high from the first overflow/underflow until reset. Without it an error bit
// is high only in the cycle after the offending edge.
//
// CNT_W must satisfy 2**CNT_W > DEPTH.

module fifo_status_bank #(
    parameter int unsigned BITBUS = 3,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_out,
    input  logic [BITBUS-1:0] umbralMF_out,
    input  logic [BITBUS-1:0] umbralVC_out,
    input  logic [BITBUS-1:0] umbralD_out,
    input  logic [4:0]        push,
    input  logic [4:0]        pop,
    output logic [4:0]        Fifo_empties,
    output logic [4:0]        Fifo_errors,
    output logic [4:0]        almost_full,
    output logic [4:0]        almost_empty
);

    localparam int unsigned      NumFifo = 5;
    localparam logic [CNT_W-1:0] DepthC  = CNT_W'(DEPTH);

    // Clamping at load keeps DEPTH - thr non-negative in every later compare.
    function automatic logic [CNT_W-1:0] clamp_thr(input logic [BITBUS-1:0] v);
        if (32'(v) > DEPTH) begin
            return DepthC;
        end
        return CNT_W'(v);
    endfunction

    logic [CNT_W-1:0] thr_mf_q, thr_vc_q, thr_d_q;
    logic [CNT_W-1:0] thr_sel [NumFifo];

    logic [CNT_W-1:0] cnt_q [NumFifo];
    logic [CNT_W-1:0] cnt_d [NumFifo];
    logic [4:0]       err_now;

    logic [4:0] empties_q, empties_d;
    logic [4:0] errors_q, errors_d;
    logic [4:0] afull_q, afull_d;
    logic [4:0] aempty_q, aempty_d;

    // Threshold registers: reload on every init edge, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            thr_mf_q <= '0;
            thr_vc_q <= '0;
            thr_d_q  <= '0;
        end else if (init_out) begin
            thr_mf_q <= clamp_thr(umbralMF_out);
            thr_vc_q <= clamp_thr(umbralVC_out);
            thr_d_q  <= clamp_thr(umbralD_out);
        end
    end

    // Per-FIFO next count and error detection; counters saturate, never wrap.
    always_comb begin
        err_now = '0;
        for (int i = 0; i < NumFifo; i++) begin
            cnt_d[i] = cnt_q[i];
            unique case ({push[i], pop[i]})
                2'b10: begin
                    if (cnt_q[i] == DepthC) begin
                        err_now[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (cnt_q[i] == '0) begin
                        err_now[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                2'b11: begin
                    // Only the legal half of a simultaneous push/pop takes effect.
                    if (cnt_q[i] == '0) begin
                        cnt_d[i]   = CNT_W'(1);
                        err_now[i] = 1'b1;
                    end else if (cnt_q[i] == DepthC) begin
                        cnt_d[i]   = DepthC - CNT_W'(1);
                        err_now[i] = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags from the next count and the currently latched thresholds.
    always_comb begin
        thr_sel[0] = thr_mf_q;
        thr_sel[1] = thr_vc_q;
        thr_sel[2] = thr_vc_q;
        thr_sel[3] = thr_d_q;
        thr_sel[4] = thr_d_q;
        empties_d  = '0;
        afull_d    = '0;
        aempty_d   = '0;
        for (int i = 0; i < NumFifo; i++) begin
            empties_d[i] = (cnt_d[i] == '0);
            aempty_d[i]  = (cnt_d[i] <= thr_sel[i]);
            afull_d[i]   = (cnt_d[i] >= (DepthC - thr_sel[i]));
        end
`ifdef FIFO_ERR_STICKY_EN
        errors_d = errors_q | err_now;
`else
        errors_d = err_now;
`endif
    end

    // Counter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumFifo; i++) begin
                cnt_q[i] <= '0;
            end
            empties_q <= 5'b11111;
            errors_q  <= 5'b00000;
            afull_q   <= 5'b00000;
            aempty_q  <= 5'b11111;
        end else begin
            for (int i = 0; i < NumFifo; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            empties_q <= empties_d;
            errors_q  <= errors_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    assign Fifo_empties = empties_q;
    assign Fifo_errors  = errors_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

endmodule
